aclk_alarm_ctrl: RTL

//  Keypad-entry controller for the alarm clock. Collects four BCD digits from
//  the keypad into an entry buffer and range-checks them as HH:MM. On the ALARM
//  key it pulses load_new_a to the alarm register; on the TIME key it pulses

---
 rtl/aclk_alarm_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aclk_alarm_ctrl.sv
// Alarm clock keypad-entry controller: gathers four BCD digits as HH:MM,
// validates them and commits to the alarm or time register; also runs a timed alarm display.
module aclk_alarm_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter logic [3:0]  KEY_ALARM   = 4'hA,
    parameter logic [3:0]  KEY_TIME    = 4'hB
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       one_second_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_i,
    output logic [3:0] new_ms_hr_o,
    output logic [3:0] new_ls_hr_o,
    output logic [3:0] new_ms_min_o,
    output logic [3:0] new_ls_min_o,
    output logic       load_new_a_o,
    output logic       load_new_c_o,
    output logic       entry_err_o,
    output logic       show_new_time_o,
    output logic       show_a_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_SEC + 1);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     digits_q, digits_d;
    logic            load_a_q, load_a_d;
    logic            load_c_q, load_c_d;
    logic            err_q, err_d;
    logic            show_new_q, show_new_d;
    logic            show_a_q, show_a_d;

    logic            is_digit_c;
    logic            is_alarm_c;
    logic            is_time_c;
    logic            digits_ok_c;
    logic            timeout_c;

    assign is_digit_c = key_i <= 4'd9;
    assign is_alarm_c = key_i == KEY_ALARM;
    assign is_time_c  = key_i == KEY_TIME;
    assign timeout_c  = timer_q == TW'(TIMEOUT_SEC - 1);

    // HH:MM range check on the buffer as it stands
    assign digits_ok_c = (digits_q[15:12] <= 4'd2) &&
                         (digits_q[11:8]  <= 4'd9) &&
                         !((digits_q[15:12] == 4'd2) && (digits_q[11:8] > 4'd3)) &&
                         (digits_q[7:4]   <= 4'd5) &&
                         (digits_q[3:0]   <= 4'd9);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        digits_d = digits_q;
        load_a_d = 1'b0;
        load_c_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid_i && is_digit_c) begin
                    digits_d = {12'h000, key_i};
                    cnt_d    = CW'(1);
                    timer_d  = '0;
                    state_d  = S_ENTRY;
                end else if (key_valid_i && is_alarm_c) begin
                    timer_d = '0;
                    state_d = S_SHOW;
                end
            end
            S_ENTRY: begin
                if (key_valid_i && is_digit_c) begin
                    digits_d = {digits_q[11:0], key_i};
                    if (cnt_q < CW'(4)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    timer_d = '0;
                end else if (key_valid_i && (is_alarm_c || is_time_c)) begin
                    if ((cnt_q == CW'(4)) && digits_ok_c) begin
                        load_a_d = is_alarm_c;
                        load_c_d = !is_alarm_c;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (one_second_i) begin
                    if (timeout_c) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_SHOW: begin
                // Any strobe here is swallowed as a dismiss
                if (key_valid_i) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (one_second_i) begin
                    if (timeout_c) begin
                        timer_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase

        show_new_d = state_d == S_ENTRY;
        show_a_d   = state_d == S_SHOW;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            digits_q   <= '0;
            load_a_q   <= 1'b0;
            load_c_q   <= 1'b0;
            err_q      <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            digits_q   <= digits_d;
            load_a_q   <= load_a_d;
            load_c_q   <= load_c_d;
            err_q      <= err_d;
            show_new_q <= show_new_d;
            show_a_q   <= show_a_d;
        end
    end

    assign new_ms_hr_o     = digits_q[15:12];
    assign new_ls_hr_o     = digits_q[11:8];
    assign new_ms_min_o    = digits_q[7:4];
    assign new_ls_min_o    = digits_q[3:0];
    assign load_new_a_o    = load_a_q;
    assign load_new_c_o    = load_c_q;
    assign entry_err_o     = err_q;
    assign show_new_time_o = show_new_q;
    assign show_a_o        = show_a_q;

endmodule
